// File: rtl/sar_pkg.sv
// Shared definitions for the SAR ADC sequencer and its per-bit slices.
package sar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_DONE    = 2'd3
  } sar_state_t;

  localparam int SAR_NBITS = 8;

  // Slice VOUT encodings, shared with the FSM_sub comparator slices
  localparam logic [2:0] VOUT_RESET = 3'b100;
  localparam logic [2:0] VOUT_HIGH  = 3'b001;
  localparam logic [2:0] VOUT_LOW   = 3'b010;

  // Phase timer width: enough to hold the longer of the sample and bit windows
  function automatic int sar_tmr_w(input int sample_cyc, input int settle_cyc);
    int m;
    m = (sample_cyc > settle_cyc + 1) ? sample_cyc : settle_cyc + 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sar_phase_timer.sv
// Loadable down-counter with a terminal-count flag; times both the sample
// phase and the per-bit settle window.
module sar_phase_timer
  import sar_pkg::*;
#(
  parameter int TMR_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_load_val,
  output logic [TMR_W-1:0] o_cnt_nxt,
  output logic             o_tc
);

  logic [TMR_W-1:0] r_cnt;
  logic [TMR_W-1:0] w_cnt_nxt;

  // Next count: a load wins, otherwise count down and rest at zero
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_load) begin
      w_cnt_nxt = i_load_val;
    end else if (r_cnt != '0) begin
      w_cnt_nxt = r_cnt - TMR_W'(1);
    end
  end

  // Count register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  // The next value lets the sequencer register outputs aligned with the count
  assign o_cnt_nxt = w_cnt_nxt;
  assign o_tc      = (r_cnt == '0);

endmodule

// File: rtl/sar_sequencer.sv
// SAR ADC control stage: sample, then MSB-to-LSB decisions through one-hot
// slice enables, result handed off over a DVALID/DREADY handshake.
module sar_sequencer
  import sar_pkg::*;
#(
  parameter int NBITS      = SAR_NBITS,
  parameter int SAMPLE_CYC = 2,
  parameter int SETTLE_CYC = 1
) (
  input  logic             CLK,
  input  logic             VRESET_N,
  input  logic             VSTART,
  input  logic             VABORT,
  input  logic             VCOMP,
  output logic [NBITS-1:0] VENABLE,
  output logic             VRESET_SLICE,
  output logic             VSAMPLE,
  output logic             VBUSY,
  output logic [NBITS-1:0] DOUT,
  output logic             DVALID,
  input  logic             DREADY
);

  localparam int TMR_W = sar_tmr_w(SAMPLE_CYC, SETTLE_CYC);
  localparam int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;

  sar_state_t       r_state;
  sar_state_t       w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [NBITS-1:0] r_dout;
  logic [NBITS-1:0] w_dout_nxt;

  logic             w_tmr_load;
  logic [TMR_W-1:0] w_tmr_val;
  logic [TMR_W-1:0] w_tmr_nxt;
  logic             w_tmr_tc;

  logic [NBITS-1:0] r_venable;
  logic             r_rslice;
  logic             r_sample;
  logic             r_busy;
  logic             r_dvalid;
  logic [NBITS-1:0] w_venable_nxt;
  logic             w_rslice_nxt;
  logic             w_sample_nxt;
  logic             w_busy_nxt;
  logic             w_dvalid_nxt;

  sar_phase_timer #(
    .TMR_W (TMR_W)
  ) u_timer (
    .i_clk      (CLK),
    .i_rst_n    (VRESET_N),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_cnt_nxt  (w_tmr_nxt),
    .o_tc       (w_tmr_tc)
  );

  // Next state, bit index, result and timer load; abort outranks everything else
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_dout_nxt  = r_dout;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    if (VABORT) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (VSTART) begin
            w_state_nxt = ST_SAMPLE;
            w_tmr_load  = 1'b1;
            w_tmr_val   = TMR_W'(SAMPLE_CYC - 1);
            w_dout_nxt  = '0;
          end
        end
        ST_SAMPLE: begin
          if (w_tmr_tc) begin
            w_state_nxt = ST_CONVERT;
            w_idx_nxt   = IDX_W'(NBITS - 1);
            w_tmr_load  = 1'b1;
            w_tmr_val   = TMR_W'(SETTLE_CYC);
          end
        end
        ST_CONVERT: begin
          // Terminal count marks the enable cycle; this edge is the decision edge
          if (w_tmr_tc) begin
            w_dout_nxt[r_idx] = VCOMP;
            if (r_idx == '0) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_idx_nxt  = r_idx - IDX_W'(1);
              w_tmr_load = 1'b1;
              w_tmr_val  = TMR_W'(SETTLE_CYC);
            end
          end
        end
        ST_DONE: begin
          if (DREADY) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state, index and count so the registered
  // outputs line up with the cycle they describe
  always_comb begin
    w_venable_nxt = '0;
    if (w_state_nxt == ST_CONVERT && w_tmr_nxt == '0) begin
      w_venable_nxt = {{(NBITS-1){1'b0}}, 1'b1} << w_idx_nxt;
    end
    w_rslice_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_SAMPLE);
    w_sample_nxt = (w_state_nxt == ST_SAMPLE);
    w_busy_nxt   = (w_state_nxt == ST_SAMPLE) || (w_state_nxt == ST_CONVERT);
    w_dvalid_nxt = (w_state_nxt == ST_DONE);
  end

  // State, index, result and output registers
  always_ff @(posedge CLK) begin
    if (!VRESET_N) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_dout    <= '0;
      r_venable <= '0;
      r_rslice  <= 1'b1;
      r_sample  <= 1'b0;
      r_busy    <= 1'b0;
      r_dvalid  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_dout    <= w_dout_nxt;
      r_venable <= w_venable_nxt;
      r_rslice  <= w_rslice_nxt;
      r_sample  <= w_sample_nxt;
      r_busy    <= w_busy_nxt;
      r_dvalid  <= w_dvalid_nxt;
    end
  end

  assign VENABLE      = r_venable;
  assign VRESET_SLICE = r_rslice;
  assign VSAMPLE      = r_sample;
  assign VBUSY        = r_busy;
  assign DOUT         = r_dout;
  assign DVALID       = r_dvalid;

endmodule

// File: tb/tb_sar_sequencer.sv
// Directed bench for sar_sequencer: default instance (a_*) and a fast
// instance with SAMPLE_CYC=1, SETTLE_CYC=0 (b_*).
module tb_sar_sequencer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       a_rst_n, a_start, a_abort, a_comp, a_dready;
  logic [7:0] a_venable, a_dout;
  logic       a_rslice, a_sample, a_busy, a_dvalid;

  logic       b_rst_n, b_start, b_abort, b_comp, b_dready;
  logic [7:0] b_venable, b_dout;
  logic       b_rslice, b_sample, b_busy, b_dvalid;

  int checks   = 0;
  int failures = 0;

  sar_sequencer u_dut_a (
    .CLK          (CLK),
    .VRESET_N     (a_rst_n),
    .VSTART       (a_start),
    .VABORT       (a_abort),
    .VCOMP        (a_comp),
    .VENABLE      (a_venable),
    .VRESET_SLICE (a_rslice),
    .VSAMPLE      (a_sample),
    .VBUSY        (a_busy),
    .DOUT         (a_dout),
    .DVALID       (a_dvalid),
    .DREADY       (a_dready)
  );

  sar_sequencer #(
    .NBITS      (8),
    .SAMPLE_CYC (1),
    .SETTLE_CYC (0)
  ) u_dut_b (
    .CLK          (CLK),
    .VRESET_N     (b_rst_n),
    .VSTART       (b_start),
    .VABORT       (b_abort),
    .VCOMP        (b_comp),
    .VENABLE      (b_venable),
    .VRESET_SLICE (b_rslice),
    .VSAMPLE      (b_sample),
    .VBUSY        (b_busy),
    .DOUT         (b_dout),
    .DVALID       (b_dvalid),
    .DREADY       (b_dready)
  );

  // Comparator model: outside an enable cycle drive 1 so a mistimed decision shows up
  function automatic logic comp_for(input logic [7:0] en, input logic [7:0] pat);
    if (en == 8'h00) return 1'b1;
    return |(en & pat);
  endfunction

  // Expected one-hot enable for the default instance, e edges after start
  function automatic logic [7:0] exp_en_a(input int e);
    logic [7:0] one;
    one = 8'h01;
    if (e >= 3 && e <= 17 && ((e - 3) % 2) == 0) return one << (7 - (e - 3) / 2);
    return 8'h00;
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Start a conversion on A and run it to DONE with the given decision pattern
  task automatic run_a(input logic [7:0] pat);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int e = 1; e <= 18; e++) begin
      a_comp = comp_for(a_venable, pat);
      tick();
    end
  endtask

  task automatic test_reset;
    a_rst_n = 1'b0; a_start = 1'b0; a_abort = 1'b0; a_comp = 1'b0; a_dready = 1'b0;
    b_rst_n = 1'b0; b_start = 1'b0; b_abort = 1'b0; b_comp = 1'b0; b_dready = 1'b0;
    tick();
    tick();
    checks++;
    if ({a_venable, a_rslice, a_sample, a_busy, a_dout, a_dvalid} !== {8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL reset_a got ven=%h rs=%b smp=%b busy=%b dout=%h dv=%b exp ven=00 rs=1 smp=0 busy=0 dout=00 dv=0",
               a_venable, a_rslice, a_sample, a_busy, a_dout, a_dvalid);
    end
    checks++;
    if ({b_venable, b_rslice, b_sample, b_busy, b_dout, b_dvalid} !== {8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL reset_b got ven=%h rs=%b smp=%b busy=%b dout=%h dv=%b exp ven=00 rs=1 smp=0 busy=0 dout=00 dv=0",
               b_venable, b_rslice, b_sample, b_busy, b_dout, b_dvalid);
    end
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    tick();
    checks++;
    if ({a_rslice, a_busy} !== 2'b10) begin
      failures++;
      $display("FAIL idle_after_reset got rs=%b busy=%b exp rs=1 busy=0", a_rslice, a_busy);
    end
  endtask

  task automatic test_conversion;
    a_start = 1'b1;
    a_comp  = 1'b1;
    tick();
    a_start = 1'b0;
    checks++;
    if ({a_sample, a_busy, a_rslice, a_dout} !== {1'b1, 1'b1, 1'b1, 8'h00}) begin
      failures++;
      $display("FAIL sample_entry got smp=%b busy=%b rs=%b dout=%h exp 1 1 1 00", a_sample, a_busy, a_rslice, a_dout);
    end
    for (int e = 1; e <= 18; e++) begin
      a_comp = comp_for(a_venable, 8'hB2);
      tick();
      checks++;
      if (a_venable !== exp_en_a(e)) begin
        failures++;
        $display("FAIL venable_e%0d got %h exp %h", e, a_venable, exp_en_a(e));
      end
      checks++;
      if (a_dvalid !== (e == 18)) begin
        failures++;
        $display("FAIL dvalid_e%0d got %b exp %b", e, a_dvalid, (e == 18));
      end
      checks++;
      if ({a_sample, a_rslice, a_busy} !== {(e < 2), (e < 2), (e < 18)}) begin
        failures++;
        $display("FAIL ctrl_e%0d got smp=%b rs=%b busy=%b exp %b %b %b",
                 e, a_sample, a_rslice, a_busy, (e < 2), (e < 2), (e < 18));
      end
    end
    checks++;
    if (a_dout !== 8'hB2) begin
      failures++;
      $display("FAIL dout_b2 got %h exp b2", a_dout);
    end
  endtask

  task automatic test_backpressure;
    a_dready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({a_dvalid, a_dout} !== {1'b1, 8'hB2}) begin
        failures++;
        $display("FAIL hold_%0d got dv=%b dout=%h exp dv=1 dout=b2", i, a_dvalid, a_dout);
      end
    end
    a_dready = 1'b1;
    tick();
    a_dready = 1'b0;
    checks++;
    if ({a_dvalid, a_rslice, a_busy, a_dout} !== {1'b0, 1'b1, 1'b0, 8'hB2}) begin
      failures++;
      $display("FAIL handshake got dv=%b rs=%b busy=%b dout=%h exp 0 1 0 b2", a_dvalid, a_rslice, a_busy, a_dout);
    end
  endtask

  task automatic test_back_to_back;
    a_start = 1'b1;
    tick();
    for (int e = 1; e <= 18; e++) begin
      a_comp = comp_for(a_venable, 8'h3C);
      tick();
      checks++;
      if ({a_dvalid, a_sample} !== {(e == 18), (e == 1)}) begin
        failures++;
        $display("FAIL b2b_e%0d got dv=%b smp=%b exp %b %b", e, a_dvalid, a_sample, (e == 18), (e == 1));
      end
    end
    checks++;
    if (a_dout !== 8'h3C) begin
      failures++;
      $display("FAIL b2b_dout got %h exp 3c", a_dout);
    end
    a_dready = 1'b1;
    tick();
    checks++;
    if ({a_dvalid, a_sample, a_busy} !== 3'b000) begin
      failures++;
      $display("FAIL start_in_done got dv=%b smp=%b busy=%b exp 0 0 0", a_dvalid, a_sample, a_busy);
    end
    a_dready = 1'b0;
    tick();
    checks++;
    if ({a_sample, a_busy, a_dout} !== {1'b1, 1'b1, 8'h00}) begin
      failures++;
      $display("FAIL restart got smp=%b busy=%b dout=%h exp 1 1 00", a_sample, a_busy, a_dout);
    end
    a_start = 1'b0;
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    checks++;
    if ({a_sample, a_busy, a_rslice} !== 3'b001) begin
      failures++;
      $display("FAIL abort_sample got smp=%b busy=%b rs=%b exp 0 0 1", a_sample, a_busy, a_rslice);
    end
  endtask

  task automatic test_abort;
    logic seen_dv;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      a_comp = comp_for(a_venable, 8'hB2);
      tick();
    end
    a_abort = 1'b1;
    a_comp  = 1'b1;
    tick();
    a_abort = 1'b0;
    checks++;
    if ({a_venable, a_rslice, a_busy, a_dvalid, a_dout} !== {8'h00, 1'b1, 1'b0, 1'b0, 8'hA0}) begin
      failures++;
      $display("FAIL abort_bit4 got ven=%h rs=%b busy=%b dv=%b dout=%h exp 00 1 0 0 a0",
               a_venable, a_rslice, a_busy, a_dvalid, a_dout);
    end
    seen_dv = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen_dv = seen_dv | a_dvalid | a_busy;
    end
    checks++;
    if (seen_dv !== 1'b0) begin
      failures++;
      $display("FAIL abort_quiet got activity=%b exp 0", seen_dv);
    end
    a_abort = 1'b1;
    a_start = 1'b1;
    tick();
    a_abort = 1'b0;
    a_start = 1'b0;
    checks++;
    if ({a_sample, a_busy} !== 2'b00) begin
      failures++;
      $display("FAIL abort_wins got smp=%b busy=%b exp 0 0", a_sample, a_busy);
    end
  endtask

  task automatic test_reset_mid;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    a_rst_n = 1'b0;
    tick();
    checks++;
    if ({a_venable, a_rslice, a_sample, a_busy, a_dout, a_dvalid} !== {8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL reset_in_sample got ven=%h rs=%b smp=%b busy=%b dout=%h dv=%b exp 00 1 0 0 00 0",
               a_venable, a_rslice, a_sample, a_busy, a_dout, a_dvalid);
    end
    a_rst_n = 1'b1;
    tick();
    run_a(8'h6D);
    checks++;
    if ({a_dvalid, a_dout} !== {1'b1, 8'h6D}) begin
      failures++;
      $display("FAIL pre_reset_done got dv=%b dout=%h exp 1 6d", a_dvalid, a_dout);
    end
    a_rst_n = 1'b0;
    tick();
    checks++;
    if ({a_venable, a_rslice, a_sample, a_busy, a_dout, a_dvalid} !== {8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL reset_in_done got ven=%h rs=%b smp=%b busy=%b dout=%h dv=%b exp 00 1 0 0 00 0",
               a_venable, a_rslice, a_sample, a_busy, a_dout, a_dvalid);
    end
    a_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fast;
    logic [7:0] exp_en;
    logic [7:0] msb;
    msb = 8'h80;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    checks++;
    if ({b_sample, b_busy, b_rslice} !== 3'b111) begin
      failures++;
      $display("FAIL fast_sample got smp=%b busy=%b rs=%b exp 1 1 1", b_sample, b_busy, b_rslice);
    end
    for (int e = 1; e <= 9; e++) begin
      b_comp = comp_for(b_venable, 8'h5C);
      tick();
      exp_en = (e <= 8) ? (msb >> (e - 1)) : 8'h00;
      checks++;
      if (b_venable !== exp_en) begin
        failures++;
        $display("FAIL fast_venable_e%0d got %h exp %h", e, b_venable, exp_en);
      end
      checks++;
      if (b_dvalid !== (e == 9)) begin
        failures++;
        $display("FAIL fast_dvalid_e%0d got %b exp %b", e, b_dvalid, (e == 9));
      end
    end
    checks++;
    if (b_dout !== 8'h5C) begin
      failures++;
      $display("FAIL fast_dout got %h exp 5c", b_dout);
    end
    b_dready = 1'b1;
    tick();
    b_dready = 1'b0;
    checks++;
    if ({b_dvalid, b_busy} !== 2'b00) begin
      failures++;
      $display("FAIL fast_handshake got dv=%b busy=%b exp 0 0", b_dvalid, b_busy);
    end
  endtask

  initial begin
    test_reset();
    test_conversion();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_fast();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got no_finish exp finish");
    $fatal(1, "timeout");
  end

endmodule
